// File: rtl/matrix_sum_arbiter.sv
// rtl/matrix_sum_arbiter.sv - round-robin arbiter/sequencer sharing one matrix_sum adder
// Optional WAIT-state timeout enabled by defining MATRIX_ARB_TIMEOUT_EN.
module matrix_sum_arbiter #(
    parameter int NUM_REQ        = 4,
    parameter int MATRIX_SIZE_M  = 4,
    parameter int MATRIX_SIZE_N  = 3,
    parameter int DATA_WIDTH     = 16,
    parameter int TIMEOUT_CYCLES = 8,
    localparam int SIZE_BLOCK    = MATRIX_SIZE_M * MATRIX_SIZE_N * DATA_WIDTH,
    localparam int ID_W          = $clog2(NUM_REQ)
) (
    input  logic                          i_clk,
    input  logic                          i_rst_n,
    input  logic [NUM_REQ-1:0]            i_req,
    input  logic [NUM_REQ*SIZE_BLOCK-1:0] i_matrix_a,
    input  logic [NUM_REQ*SIZE_BLOCK-1:0] i_matrix_b,
    output logic [NUM_REQ-1:0]            o_ack,
    output logic [SIZE_BLOCK-1:0]         o_matrix,
    output logic [ID_W-1:0]               o_grant_id,
    output logic                          o_busy,
    output logic                          o_error,
    output logic                          o_sum_cmd,
    output logic [SIZE_BLOCK-1:0]         o_sum_a,
    output logic [SIZE_BLOCK-1:0]         o_sum_b,
    input  logic [SIZE_BLOCK-1:0]         i_sum_matrix,
    input  logic                          i_sum_ready
);

    if (NUM_REQ < 2 || TIMEOUT_CYCLES < 1) begin : g_bad_param
        $error("matrix_sum_arbiter: NUM_REQ must be >= 2 and TIMEOUT_CYCLES >= 1");
    end

    typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_WAIT, ST_DONE} state_t;

    state_t                 state_q, state_d;
    logic [ID_W-1:0]        grant_q, grant_d;
    logic [ID_W-1:0]        last_q, last_d;
    logic [NUM_REQ-1:0]     ack_q, ack_d;
    logic                   cmd_q, cmd_d;
    logic                   busy_q, busy_d;
    logic [SIZE_BLOCK-1:0]  matrix_q, matrix_d;
    logic [SIZE_BLOCK-1:0]  slice_a [NUM_REQ];
    logic [SIZE_BLOCK-1:0]  slice_b [NUM_REQ];
    logic [ID_W-1:0]        pick;
    logic [ID_W-1:0]        idx;
    logic                   found;

`ifdef MATRIX_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             err_q, err_d;
`endif

    for (genvar r = 0; r < NUM_REQ; r++) begin : g_slice
        assign slice_a[r] = i_matrix_a[r*SIZE_BLOCK +: SIZE_BLOCK];
        assign slice_b[r] = i_matrix_b[r*SIZE_BLOCK +: SIZE_BLOCK];
    end

    // Rotating priority: scan upward from the requester after the last grant.
    always_comb begin
        pick  = last_q;
        idx   = last_q;
        found = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            idx = (idx == ID_W'(NUM_REQ - 1)) ? '0 : idx + 1'b1;
            if (!found && i_req[idx]) begin
                found = 1'b1;
                pick  = idx;
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        grant_d  = grant_q;
        last_d   = last_q;
        matrix_d = matrix_q;
        ack_d    = '0;
        cmd_d    = 1'b0;
`ifdef MATRIX_ARB_TIMEOUT_EN
        cnt_d    = cnt_q;
        err_d    = 1'b0;
`endif
        case (state_q)
            ST_IDLE: begin
                if (|i_req) begin
                    grant_d = pick;
                    last_d  = pick;
                    cmd_d   = 1'b1;
                    state_d = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                state_d = ST_WAIT;
`ifdef MATRIX_ARB_TIMEOUT_EN
                cnt_d   = '0;
`endif
            end
            ST_WAIT: begin
                if (i_sum_ready) begin
                    matrix_d = i_sum_matrix;
                    ack_d    = NUM_REQ'(1) << grant_q;
                    state_d  = ST_DONE;
                end
`ifdef MATRIX_ARB_TIMEOUT_EN
                else begin
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                        ack_d   = NUM_REQ'(1) << grant_q;
                        err_d   = 1'b1;
                        state_d = ST_DONE;
                    end
                end
`endif
            end
            default: state_d = ST_IDLE;
        endcase
        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q  <= ST_IDLE;
            grant_q  <= '0;
            last_q   <= ID_W'(NUM_REQ - 1);
            ack_q    <= '0;
            cmd_q    <= 1'b0;
            busy_q   <= 1'b0;
            matrix_q <= '0;
`ifdef MATRIX_ARB_TIMEOUT_EN
            cnt_q    <= '0;
            err_q    <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            last_q   <= last_d;
            ack_q    <= ack_d;
            cmd_q    <= cmd_d;
            busy_q   <= busy_d;
            matrix_q <= matrix_d;
`ifdef MATRIX_ARB_TIMEOUT_EN
            cnt_q    <= cnt_d;
            err_q    <= err_d;
`endif
        end
    end

    assign o_ack      = ack_q;
    assign o_matrix   = matrix_q;
    assign o_grant_id = grant_q;
    assign o_busy     = busy_q;
    assign o_sum_cmd  = cmd_q;
    assign o_sum_a    = slice_a[grant_q];
    assign o_sum_b    = slice_b[grant_q];
`ifdef MATRIX_ARB_TIMEOUT_EN
    assign o_error    = err_q;
`else
    assign o_error    = 1'b0;
`endif

endmodule

// File: tb/tb_matrix_sum_arbiter.sv
// tb/tb_matrix_sum_arbiter.sv - randomized self-checking bench for matrix_sum_arbiter
module tb_matrix_sum_arbiter;

    localparam int NUM_REQ        = 4;
    localparam int MATRIX_SIZE_M  = 4;
    localparam int MATRIX_SIZE_N  = 3;
    localparam int DATA_WIDTH     = 16;
    localparam int TIMEOUT_CYCLES = 8;
    localparam int ELEMS          = MATRIX_SIZE_M * MATRIX_SIZE_N;
    localparam int SB             = ELEMS * DATA_WIDTH;
    localparam int ID_W           = $clog2(NUM_REQ);
`ifdef MATRIX_ARB_TIMEOUT_EN
    localparam bit TMO_EN = 1'b1;
`else
    localparam bit TMO_EN = 1'b0;
`endif

    logic                    i_clk        = 1'b0;
    logic                    i_rst_n      = 1'b0;
    logic [NUM_REQ-1:0]      i_req        = '0;
    logic [NUM_REQ*SB-1:0]   i_matrix_a   = '0;
    logic [NUM_REQ*SB-1:0]   i_matrix_b   = '0;
    logic [SB-1:0]           i_sum_matrix = '0;
    logic                    i_sum_ready  = 1'b0;
    logic [NUM_REQ-1:0]      o_ack;
    logic [SB-1:0]           o_matrix;
    logic [ID_W-1:0]         o_grant_id;
    logic                    o_busy;
    logic                    o_error;
    logic                    o_sum_cmd;
    logic [SB-1:0]           o_sum_a;
    logic [SB-1:0]           o_sum_b;

    always #5 i_clk = ~i_clk;

    matrix_sum_arbiter #(
        .NUM_REQ        (NUM_REQ),
        .MATRIX_SIZE_M  (MATRIX_SIZE_M),
        .MATRIX_SIZE_N  (MATRIX_SIZE_N),
        .DATA_WIDTH     (DATA_WIDTH),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) dut (
        .i_clk        (i_clk),
        .i_rst_n      (i_rst_n),
        .i_req        (i_req),
        .i_matrix_a   (i_matrix_a),
        .i_matrix_b   (i_matrix_b),
        .o_ack        (o_ack),
        .o_matrix     (o_matrix),
        .o_grant_id   (o_grant_id),
        .o_busy       (o_busy),
        .o_error      (o_error),
        .o_sum_cmd    (o_sum_cmd),
        .o_sum_a      (o_sum_a),
        .o_sum_b      (o_sum_b),
        .i_sum_matrix (i_sum_matrix),
        .i_sum_ready  (i_sum_ready)
    );

    int              errors = 0;
    int              checks = 0;
    int              cyc = 0;
    int              issue_cyc = -10;
    int              ack_cyc = -10;
    int              rdy_cyc = -1;
    int              cur_g = 0;
    int              last_g = NUM_REQ - 1;
    bit              timed_out = 1'b0;
    bit              rand_en = 1'b0;
    bit              release_pending = 1'b0;
    int              min_delay = 0;
    int              max_delay = 0;
    logic [SB-1:0]   exp_matrix = '0;
    logic [SB-1:0]   ref_a [NUM_REQ];
    logic [SB-1:0]   ref_b [NUM_REQ];
    logic [NUM_REQ-1:0] sticky = '0;
    int              gq[$];

    task automatic check(input string tag, input logic [SB-1:0] got, input logic [SB-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %h expected %h", tag, cyc, got, exp);
        end
    endtask

    function automatic logic [SB-1:0] rand_block();
        logic [SB-1:0] blk;
        for (int e = 0; e < ELEMS; e++)
            blk[e*DATA_WIDTH +: DATA_WIDTH] = ($urandom_range(0, 7) == 0) ? '1 : DATA_WIDTH'($urandom);
        return blk;
    endfunction

    function automatic logic [SB-1:0] add_blocks(input logic [SB-1:0] a, input logic [SB-1:0] b);
        logic [SB-1:0]         s;
        logic [DATA_WIDTH-1:0] x, y;
        for (int e = 0; e < ELEMS; e++) begin
            x = a[e*DATA_WIDTH +: DATA_WIDTH];
            y = b[e*DATA_WIDTH +: DATA_WIDTH];
            s[e*DATA_WIDTH +: DATA_WIDTH] = x + y;
        end
        return s;
    endfunction

    function automatic logic [NUM_REQ-1:0] onehot(input int g);
        logic [NUM_REQ-1:0] v;
        v    = '0;
        v[g] = 1'b1;
        return v;
    endfunction

    task automatic drive_req(input int r);
        i_matrix_a[r*SB +: SB] = ref_a[r];
        i_matrix_b[r*SB +: SB] = ref_b[r];
        i_req[r] = 1'b1;
    endtask

    task automatic new_req(input int r);
        ref_a[r] = rand_block();
        ref_b[r] = rand_block();
        drive_req(r);
    endtask

    // One clock cycle: check outputs, play the adder, update requesters, predict the next grant.
    task automatic step(input logic [NUM_REQ-1:0] force_raise);
        int  d;
        int  g;
        bit  busy;
        @(negedge i_clk);
        cyc++;
        busy = (cyc >= issue_cyc) && (cyc <= ack_cyc);
        if (cyc == ack_cyc && !timed_out)
            exp_matrix = add_blocks(ref_a[cur_g], ref_b[cur_g]);
        check("busy", SB'(o_busy), SB'(busy));
        check("sum_cmd", SB'(o_sum_cmd), SB'(cyc == issue_cyc));
        check("ack", SB'(o_ack), SB'((cyc == ack_cyc) ? onehot(cur_g) : '0));
        check("error", SB'(o_error), SB'(cyc == ack_cyc && timed_out));
        check("matrix", o_matrix, exp_matrix);
        check("grant_id", SB'(o_grant_id), SB'(cur_g));
        if (cyc == issue_cyc) begin
            check("sum_a", o_sum_a, ref_a[cur_g]);
            check("sum_b", o_sum_b, ref_b[cur_g]);
            d         = int'($urandom_range(max_delay, min_delay));
            rdy_cyc   = cyc + 1 + d;
            timed_out = TMO_EN && (d >= TIMEOUT_CYCLES);
            ack_cyc   = timed_out ? cyc + 1 + TIMEOUT_CYCLES : rdy_cyc + 1;
        end
        i_sum_ready = (cyc == rdy_cyc) && !timed_out;
        i_sum_matrix = i_sum_ready ? add_blocks(o_sum_a, o_sum_b) : rand_block();
        if (cyc == ack_cyc) begin
            i_req[cur_g] = 1'b0;
            if (sticky[cur_g]) new_req(cur_g);
        end
        for (int r = 0; r < NUM_REQ; r++) begin
            if (!i_req[r] && force_raise[r]) drive_req(r);
            else if (!i_req[r] && rand_en && $urandom_range(0, 3) == 0) new_req(r);
        end
        if (release_pending) begin
            i_rst_n = 1'b1;
            release_pending = 1'b0;
        end
        if (i_rst_n && !busy && issue_cyc <= cyc && i_req != '0) begin
            g = -1;
            for (int i = 1; i <= NUM_REQ; i++) begin
                if (g < 0 && i_req[(last_g + i) % NUM_REQ]) g = (last_g + i) % NUM_REQ;
            end
            cur_g     = g;
            last_g    = g;
            gq.push_back(g);
            issue_cyc = cyc + 1;
            ack_cyc   = cyc + 1000000;
            rdy_cyc   = -1;
            timed_out = 1'b0;
        end
    endtask

    task automatic drain();
        for (int n = 0; n < 200; n++) begin
            if (i_req == '0 && issue_cyc <= cyc && cyc > ack_cyc) return;
            step('0);
        end
        check("drain_timeout", SB'(1), SB'(0));
    endtask

    logic [SB-1:0] tmp;
    bit            reached;

    initial begin
        for (int r = 0; r < NUM_REQ; r++) begin
            ref_a[r] = '0;
            ref_b[r] = '0;
        end
        step('0);
        step('0);

        ref_a[1] = {ELEMS{16'h0003}};
        ref_b[1] = {ELEMS{16'h0004}};
        release_pending = 1'b1;
        step(NUM_REQ'(2));
        drain();
        check("single_matrix", o_matrix, {ELEMS{16'h0007}});
        check("single_grant", SB'(o_grant_id), SB'(1));

        ref_a[2] = rand_block();
        ref_b[2] = rand_block();
        ref_a[2][15:0] = 16'hFFFF;
        ref_b[2][15:0] = 16'h0002;
        step(NUM_REQ'(4));
        drain();
        check("wrap_elem0", SB'(o_matrix[15:0]), SB'(16'h0001));
        tmp = add_blocks(ref_a[2], ref_b[2]);
        check("wrap_rest", SB'(o_matrix[SB-1:16]), SB'(tmp[SB-1:16]));

        gq.delete();
        ref_a[0] = rand_block(); ref_b[0] = rand_block();
        ref_a[2] = rand_block(); ref_b[2] = rand_block();
        sticky = NUM_REQ'(5);
        step(NUM_REQ'(5));
        repeat (30) step('0);
        sticky = '0;
        drain();
        check("fair_count", SB'(gq.size() >= 6), SB'(1));
        for (int i = 1; i < gq.size(); i++) begin
            check("fair_alt", SB'(gq[i] != gq[i-1]), SB'(1));
            check("fair_set", SB'(gq[i] == 0 || gq[i] == 2), SB'(1));
        end

        min_delay = 6;
        max_delay = 6;
        ref_a[3] = rand_block(); ref_b[3] = rand_block();
        step(NUM_REQ'(8));
        reached = 1'b0;
        for (int n = 0; n < 10 && !reached; n++) begin
            step('0);
            reached = (cyc == issue_cyc + 2);
        end
        check("reach_wait", SB'(reached), SB'(1));
        #2 i_rst_n = 1'b0;
        #1;
        check("rst_ack", SB'(o_ack), SB'(0));
        check("rst_cmd", SB'(o_sum_cmd), SB'(0));
        check("rst_busy", SB'(o_busy), SB'(0));
        check("rst_error", SB'(o_error), SB'(0));
        check("rst_matrix", o_matrix, '0);
        check("rst_grant", SB'(o_grant_id), SB'(0));
        issue_cyc = -10; ack_cyc = -10; rdy_cyc = -1; timed_out = 1'b0;
        cur_g = 0; last_g = NUM_REQ - 1; exp_matrix = '0;
        step('0);
        step('0);
        for (int r = 0; r < 3; r++) begin
            ref_a[r] = rand_block();
            ref_b[r] = rand_block();
        end
        min_delay = 0;
        max_delay = 0;
        gq.delete();
        release_pending = 1'b1;
        step(NUM_REQ'(7));
        drain();
        check("rst_order_len", SB'(gq.size()), SB'(4));
        for (int i = 0; i < gq.size() && i < 4; i++)
            check("rst_order", SB'(gq[i]), SB'(i));

`ifdef MATRIX_ARB_TIMEOUT_EN
        min_delay = 30;
        max_delay = 30;
        tmp = o_matrix;
        ref_a[1] = rand_block(); ref_b[1] = rand_block();
        step(NUM_REQ'(2));
        drain();
        check("timeout_matrix_held", o_matrix, tmp);
`endif

        min_delay = 0;
        max_delay = 3;
        rand_en = 1'b1;
        for (int n = 0; n < 3000; n++) begin
            if (n % 50 == 0) sticky = NUM_REQ'($urandom);
            step('0);
        end
        rand_en = 1'b0;
        sticky = '0;
        drain();
        step('0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
